v_vram_arbiter_3: RTL
=====================

Name: v_vram_arbiter_3

Overview:
- Shares the single vector RAM port between the three vector memory-access lanes of the three-issue core.
- Arbitrates per-lane read/write requests round-robin and drives the chosen request onto the VRAM port.
- Tracks in-flight reads and routes the returned read data back to the originating lane with a one-hot valid.
- Sits between the three per-lane vector memory access units and the VRAM.

Parameters:
- NUM_REQ, 3, number of requesting lanes; fixed at 3 in this block.
- VRAM_DW, 256, VRAM data and mask width.
- VRAM_AW, 32, VRAM address width.
- RD_LAT, 1, VRAM read latency in cycles, from ren asserted to dout valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_ren_i  in  NUM_REQ  per-lane read request
- req_wen_i  in  NUM_REQ  per-lane write request
- req_addr_i  in  NUM_REQ*VRAM_AW  per-lane address; lane i occupies slice [i*AW +: AW]
- req_mask_i  in  NUM_REQ*VRAM_DW  per-lane bit write mask
- req_din_i  in  NUM_REQ*VRAM_DW  per-lane write data
- req_gnt_o  out  NUM_REQ  one-hot grant; request accepted this cycle
- req_rvalid_o  out  NUM_REQ  one-hot; read data for lane i is on req_dout_o
- req_dout_o  out  VRAM_DW  read data, broadcast to all lanes
- vram_ren_o  out  1  VRAM read enable
- vram_wen_o  out  1  VRAM write enable
- vram_addr_o  out  VRAM_AW  VRAM address
- vram_mask_o  out  VRAM_DW  VRAM write mask
- vram_din_o  out  VRAM_DW  VRAM write data
- vram_dout_i  in  VRAM_DW  VRAM read data

Behaviour:
- Reset, synchronous: rr_ptr=0, read-tracking pipe cleared. While rst=1: req_gnt_o=0, req_rvalid_o=0, vram_ren_o=0, vram_wen_o=0.
- Request rule: lane i requests when ren[i]|wen[i]. The lane holds the request and its addr/mask/din stable until it sees gnt[i]=1.
- Grant:
  - Combinational, same cycle as the request; at most one grant per cycle.
  - Search starts at lane rr_ptr and proceeds rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first requesting lane wins.
- rr_ptr update: on the clock edge after a grant to lane i, rr_ptr <= (i+1) mod 3. With no grant, rr_ptr holds. Wrap: a grant to lane 2 sets rr_ptr to 0.
- VRAM drive:
  - Granted lane's fields are passed through combinationally in the grant cycle.
  - With no grant: ren=wen=0, addr=0, din=0, mask=0.
- ren and wen both set on the same lane: treated as a write only. vram_wen_o=1, vram_ren_o=0, no rvalid generated. Bench flags this as a protocol warning.
- Read tracking:
  - A granted read pushes {valid=1, lane id} into an RD_LAT-deep shift pipe.
  - RD_LAT cycles after the grant cycle, rvalid[id]=1 for exactly one cycle, and req_dout_o=vram_dout_i.
  - Back-to-back reads from different lanes produce back-to-back rvalids in grant order.
- req_dout_o passes vram_dout_i through unconditionally; it is only meaningful while rvalid≠0.
- Writes: complete in the grant cycle; no response.
- Throughput: one access per cycle. No request waits more than 2 cycles while other lanes keep requesting (starvation-free).
- Reset mid-operation: in-flight reads are dropped; their rvalid never asserts. Lanes must re-issue.
- Lane id encoding: 2 bits. Value 3 is unused and never produces rvalid.

Decomposition:
- Shared package v_mem_pkg:
  - NUM_VREQ=3, VRAM_DW, VRAM_AW defaults.
  - typedef vlane_id_t (2-bit lane id).
  - typedef rd_tag_t {valid, vlane_id_t}.
- Sub-module rr_arbiter_3: pure combinational round-robin picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: gnt one-hot, gnt_id, any_gnt.
- The top level holds rr_ptr, the tag pipe and the VRAM muxing.

Test Plan:
- Reset, then lane1 read addr=0x40 alone → gnt=3'b010 in the same cycle, vram_ren_o=1, vram_addr_o=0x40. Next cycle (RD_LAT=1): rvalid=3'b010, req_dout_o=vram_dout_i. rr_ptr becomes 2.
- All three lanes hold reads continuously from rr_ptr=0 → grants 001, 010, 100, 001 on consecutive cycles; rvalid sequence matches, each one cycle later.
- Lane0 write addr=0x80, mask=all-ones, din=0xA5… while lane2 reads, rr_ptr=2 → cycle0: lane2 granted read. Cycle1: lane0 granted, vram_wen_o=1, din=0xA5…, rvalid=100 for the lane2 read.
- Lane1 asserts ren=wen=1 → vram_wen_o=1, vram_ren_o=0, no rvalid in any later cycle.
- Read granted to lane2, then rst=1 on the next cycle with RD_LAT=2 → rvalid stays 0; after reset release, rr_ptr=0 and lane0 wins a simultaneous 3-lane request.
- No requests for 10 cycles → gnt=0, vram_ren/wen=0, addr/din/mask=0, rr_ptr unchanged.

Source files
------------

// File: rtl/v_mem_pkg.sv
// Shared types for the vector memory path: lane ids, read-tracking tags and
// default VRAM geometry.
package v_mem_pkg;

  localparam int NUM_VREQ    = 3;
  localparam int VRAM_DW_DEF = 256;
  localparam int VRAM_AW_DEF = 32;

  typedef logic [1:0] vlane_id_t;

  typedef struct packed {
    logic      valid;
    vlane_id_t id;
  } rd_tag_t;

  // Next lane in round-robin order; the unused id 3 folds back to lane 0.
  function automatic vlane_id_t lane_inc(input vlane_id_t id);
    vlane_id_t nxt;
    if (id >= 2'd2) nxt = 2'd0;
    else            nxt = vlane_id_t'(id + 2'd1);
    return nxt;
  endfunction

endpackage

// File: rtl/v_vram_arbiter_3_rr.sv
// Three-way combinational round-robin picker: the first requester found
// starting at ptr wins.
module rr_arbiter_3
  import v_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output vlane_id_t  gnt_id,
  output logic       any_gnt
);

  vlane_id_t idx;

  always_comb begin
    gnt     = 3'b000;
    gnt_id  = 2'd0;
    any_gnt = 1'b0;
    idx     = (ptr == 2'd3) ? 2'd0 : ptr;
    for (int k = 0; k < 3; k++) begin
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any_gnt  = 1'b1;
      end
      idx = lane_inc(idx);
    end
  end

endmodule

// File: rtl/v_vram_arbiter_3.sv
// Shares one VRAM port among three vector lanes: round-robin grant, combinational
// pass-through of the winner, and a tag pipe that steers read data back.
module v_vram_arbiter_3
  import v_mem_pkg::*;
#(
  parameter int NUM_REQ = NUM_VREQ,
  parameter int VRAM_DW = VRAM_DW_DEF,
  parameter int VRAM_AW = VRAM_AW_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_ren_i,
  input  logic [NUM_REQ-1:0]         req_wen_i,
  input  logic [NUM_REQ*VRAM_AW-1:0] req_addr_i,
  input  logic [NUM_REQ*VRAM_DW-1:0] req_mask_i,
  input  logic [NUM_REQ*VRAM_DW-1:0] req_din_i,
  output logic [NUM_REQ-1:0]         req_gnt_o,
  output logic [NUM_REQ-1:0]         req_rvalid_o,
  output logic [VRAM_DW-1:0]         req_dout_o,
  output logic                       vram_ren_o,
  output logic                       vram_wen_o,
  output logic [VRAM_AW-1:0]         vram_addr_o,
  output logic [VRAM_DW-1:0]         vram_mask_o,
  output logic [VRAM_DW-1:0]         vram_din_o,
  input  logic [VRAM_DW-1:0]         vram_dout_i
);

  vlane_id_t    rr_ptr;
  logic [2:0]   req_p0;
  logic [2:0]   gnt_p0;
  vlane_id_t    gnt_id_p0;
  logic         any_gnt_p0;
  logic         sel_ren_p0;
  logic         sel_wen_p0;
  rd_tag_t      rd_tag_p [RD_LAT];

  // Requests are masked during reset so no grant or VRAM strobe can leak out.
  assign req_p0 = (req_ren_i | req_wen_i) & {3{~rst}};

  rr_arbiter_3 u_rr (
    .req     (req_p0),
    .ptr     (rr_ptr),
    .gnt     (gnt_p0),
    .gnt_id  (gnt_id_p0),
    .any_gnt (any_gnt_p0)
  );

  assign req_gnt_o = gnt_p0;

  always_comb begin
    sel_ren_p0  = 1'b0;
    sel_wen_p0  = 1'b0;
    vram_addr_o = '0;
    vram_mask_o = '0;
    vram_din_o  = '0;
    if (any_gnt_p0) begin
      case (gnt_id_p0)
        2'd0: begin
          sel_ren_p0  = req_ren_i[0];
          sel_wen_p0  = req_wen_i[0];
          vram_addr_o = req_addr_i[0*VRAM_AW +: VRAM_AW];
          vram_mask_o = req_mask_i[0*VRAM_DW +: VRAM_DW];
          vram_din_o  = req_din_i[0*VRAM_DW +: VRAM_DW];
        end
        2'd1: begin
          sel_ren_p0  = req_ren_i[1];
          sel_wen_p0  = req_wen_i[1];
          vram_addr_o = req_addr_i[1*VRAM_AW +: VRAM_AW];
          vram_mask_o = req_mask_i[1*VRAM_DW +: VRAM_DW];
          vram_din_o  = req_din_i[1*VRAM_DW +: VRAM_DW];
        end
        2'd2: begin
          sel_ren_p0  = req_ren_i[2];
          sel_wen_p0  = req_wen_i[2];
          vram_addr_o = req_addr_i[2*VRAM_AW +: VRAM_AW];
          vram_mask_o = req_mask_i[2*VRAM_DW +: VRAM_DW];
          vram_din_o  = req_din_i[2*VRAM_DW +: VRAM_DW];
        end
        default: ;
      endcase
    end
  end

  // A lane asserting both strobes is served as a write; no read is tracked.
  assign vram_wen_o = sel_wen_p0;
  assign vram_ren_o = sel_ren_p0 & ~sel_wen_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (any_gnt_p0) begin
      rr_ptr <= lane_inc(gnt_id_p0);
    end
  end

  // ---- stage boundary: read tags advance one slot per cycle over RD_LAT ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) rd_tag_p[i] <= '0;
    end else begin
      rd_tag_p[0] <= '{valid: vram_ren_o, id: gnt_id_p0};
      for (int i = 1; i < RD_LAT; i++) rd_tag_p[i] <= rd_tag_p[i-1];
    end
  end

  always_comb begin
    req_rvalid_o = '0;
    if (!rst && rd_tag_p[RD_LAT-1].valid) begin
      case (rd_tag_p[RD_LAT-1].id)
        2'd0:    req_rvalid_o[0] = 1'b1;
        2'd1:    req_rvalid_o[1] = 1'b1;
        2'd2:    req_rvalid_o[2] = 1'b1;
        default: ;
      endcase
    end
  end

  assign req_dout_o = vram_dout_i;

endmodule
